// File: rtl/hvac_driver.sv
// hvac_driver: fan-led heater/compressor sequencer with minimum run and anti-short-cycle lockout.
// Optional fan post-run stage is enabled by defining HVAC_FAN_POSTRUN_EN.
module hvac_driver #(
  parameter int FAN_LEAD = 2,
  parameter int MIN_RUN  = 5,
  parameter int FAN_TAIL = 3,
  parameter int MIN_OFF  = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic heating,
  input  logic cooling,
  output logic heater_on,
  output logic compressor_on,
  output logic fan_on,
  output logic lockout
);
  typedef enum logic [2:0] {IDLE, FAN_PRE, HEAT, COOL, FAN_POST, LOCKOUT} state_t;
  // Out-of-range timing never energises anything.
  localparam bit PARAMS_OK = (FAN_LEAD >= 1) && (FAN_LEAD <= 255) && (MIN_RUN >= 1) && (MIN_RUN <= 255) &&
                             (FAN_TAIL >= 1) && (FAN_TAIL <= 255) && (MIN_OFF >= 1) && (MIN_OFF <= 255);
`ifdef HVAC_FAN_POSTRUN_EN
  localparam state_t         RUN_EXIT  = FAN_POST;
  localparam logic [7:0]     EXIT_LOAD = 8'(FAN_TAIL - 1);
`else
  localparam state_t         RUN_EXIT  = LOCKOUT;
  localparam logic [7:0]     EXIT_LOAD = 8'(MIN_OFF - 1);
`endif
  state_t state;
  logic [7:0] cnt;
  logic tgt_cool;
  logic own_req, opp_req, done;
  assign own_req = tgt_cool ? cooling : heating;
  assign opp_req = tgt_cool ? heating : cooling;
  assign done    = cnt == 8'd0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      tgt_cool <= 1'b0;
    end else begin
      case (state)
        IDLE: if (PARAMS_OK && (heating != cooling)) begin
          state    <= FAN_PRE;
          cnt      <= 8'(FAN_LEAD - 1);
          tgt_cool <= cooling;
        end
        FAN_PRE: if (!own_req) state <= IDLE;
          else if (done) begin
            state <= tgt_cool ? COOL : HEAT;
            cnt   <= 8'(MIN_RUN - 1);
          end else cnt <= cnt - 8'd1;
        HEAT, COOL: if (!done) cnt <= cnt - 8'd1;
          else if (!own_req || opp_req) begin
            state <= RUN_EXIT;
            cnt   <= EXIT_LOAD;
          end
`ifdef HVAC_FAN_POSTRUN_EN
        FAN_POST: if (done) begin
            state <= LOCKOUT;
            cnt   <= 8'(MIN_OFF - 1);
          end else cnt <= cnt - 8'd1;
`endif
        LOCKOUT: if (done) state <= IDLE;
          else cnt <= cnt - 8'd1;
        default: state <= IDLE;
      endcase
    end
  end
  assign heater_on     = state == HEAT;
  assign compressor_on = state == COOL;
  assign fan_on        = (state == FAN_PRE) || (state == HEAT) || (state == COOL) || (state == FAN_POST);
  assign lockout       = state == LOCKOUT;
endmodule

// File: tb/tb_hvac_driver.sv
// tb_hvac_driver: scoreboard bench for hvac_driver; expectations adapt to HVAC_FAN_POSTRUN_EN.
module tb_hvac_driver;
`ifdef HVAC_FAN_POSTRUN_EN
  localparam bit POST = 1'b1;
`else
  localparam bit POST = 1'b0;
`endif
  // Output vector order: {heater_on, compressor_on, fan_on, lockout}
  localparam logic [3:0] I = 4'b0000, F = 4'b0010, H = 4'b1010, C = 4'b0110, L = 4'b0001;
  logic clk = 1'b0, rst = 1'b1, heating = 1'b0, cooling = 1'b0;
  logic heater_on, compressor_on, fan_on, lockout;
  int n_cmp = 0, n_mis = 0;
  logic [3:0] sb[$], obs[$];
  hvac_driver #(.FAN_LEAD(2), .MIN_RUN(5), .FAN_TAIL(3), .MIN_OFF(4)) dut (
    .clk(clk), .rst(rst), .heating(heating), .cooling(cooling),
    .heater_on(heater_on), .compressor_on(compressor_on), .fan_on(fan_on), .lockout(lockout)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] outs();
    return {heater_on, compressor_on, fan_on, lockout};
  endfunction
  task automatic apply(input logic h, input logic c, input logic [3:0] e);
    heating = h;
    cooling = c;
    sb.push_back(e);
    @(posedge clk);
    #1;
    obs.push_back(outs());
  endtask
  // Exit edge from HEAT/COOL driven with (h,c), then fan tail, lockout and IDLE.
  task automatic exit_tail(input logic h, input logic c);
    apply(h, c, POST ? F : L);
    if (POST) repeat (2) apply(1'b0, 1'b0, F);
    repeat (POST ? 4 : 3) apply(1'b0, 1'b0, L);
    apply(1'b0, 1'b0, I);
  endtask
  task automatic test_reset();
    logic [3:0] g;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    g = outs();
    n_cmp++;
    if (g !== I) begin n_mis++; $display("FAIL reset_state: got %b want %b", g, I); end
    rst = 1'b0;
    apply(1'b0, 1'b0, I);
    apply(1'b1, 1'b1, I);
    for (int i = 0; sb.size() > 0; i++) begin
      logic [3:0] e, o;
      e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL reset_idle[%0d]: got %b want %b", i, o, e); end
    end
  endtask
  task automatic test_heat_hold();
    apply(1'b1, 1'b0, F);
    apply(1'b1, 1'b0, F);
    repeat (9) apply(1'b1, 1'b0, H);
    exit_tail(1'b0, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      logic [3:0] e, o;
      e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL heat_hold[%0d]: got %b want %b", i, o, e); end
    end
  endtask
  task automatic test_pulse();
    apply(1'b1, 1'b0, F);
    apply(1'b1, 1'b0, F);
    apply(1'b1, 1'b0, H);
    repeat (4) apply(1'b0, 1'b0, H);
    exit_tail(1'b0, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      logic [3:0] e, o;
      e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL heat_pulse[%0d]: got %b want %b", i, o, e); end
    end
  endtask
  task automatic test_lockout_req();
    apply(1'b1, 1'b0, F);
    apply(1'b1, 1'b0, F);
    apply(1'b1, 1'b0, H);
    repeat (4) apply(1'b0, 1'b0, H);
    apply(1'b0, 1'b0, POST ? F : L);
    if (POST) repeat (2) apply(1'b0, 1'b1, F);
    repeat (POST ? 4 : 3) apply(1'b0, 1'b1, L);
    apply(1'b0, 1'b1, I);
    apply(1'b0, 1'b1, F);
    apply(1'b0, 1'b1, F);
    apply(1'b0, 1'b1, C);
    repeat (4) apply(1'b0, 1'b0, C);
    exit_tail(1'b0, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      logic [3:0] e, o;
      e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL lockout_req[%0d]: got %b want %b", i, o, e); end
    end
  endtask
  task automatic test_conflict();
    apply(1'b1, 1'b1, I);
    apply(1'b1, 1'b1, I);
    apply(1'b1, 1'b0, F);
    apply(1'b1, 1'b0, F);
    apply(1'b1, 1'b0, H);
    repeat (4) apply(1'b1, 1'b1, H);
    exit_tail(1'b1, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      logic [3:0] e, o;
      e = sb.pop_front(); o = obs.pop_front(); n_cmp += 2;
      if (o !== e) begin n_mis++; $display("FAIL conflict[%0d]: got %b want %b", i, o, e); end
      if (o[3] && o[2]) begin n_mis++; $display("FAIL exclusive[%0d]: got heater=1 compressor=1 want not both", i); end
    end
  endtask
  task automatic test_abort_pre();
    apply(1'b1, 1'b0, F);
    apply(1'b0, 1'b0, I);
    repeat (3) apply(1'b0, 1'b0, I);
    apply(1'b0, 1'b1, F);
    apply(1'b0, 1'b1, F);
    apply(1'b0, 1'b0, I);
    apply(1'b0, 1'b0, I);
    for (int i = 0; sb.size() > 0; i++) begin
      logic [3:0] e, o;
      e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL abort_pre[%0d]: got %b want %b", i, o, e); end
    end
  endtask
  task automatic test_reset_run();
    logic [3:0] g;
    apply(1'b0, 1'b1, F);
    apply(1'b0, 1'b1, F);
    apply(1'b0, 1'b1, C);
    apply(1'b0, 1'b1, C);
    #2 rst = 1'b1;
    #1 g = outs();
    n_cmp++;
    if (g !== I) begin n_mis++; $display("FAIL async_reset: got %b want %b", g, I); end
    @(posedge clk);
    #1 g = outs();
    n_cmp++;
    if (g !== I) begin n_mis++; $display("FAIL reset_hold: got %b want %b", g, I); end
    rst = 1'b0;
    apply(1'b0, 1'b1, F);
    apply(1'b0, 1'b1, F);
    apply(1'b0, 1'b1, C);
    repeat (4) apply(1'b0, 1'b0, C);
    exit_tail(1'b0, 1'b0);
    for (int i = 0; sb.size() > 0; i++) begin
      logic [3:0] e, o;
      e = sb.pop_front(); o = obs.pop_front(); n_cmp++;
      if (o !== e) begin n_mis++; $display("FAIL reset_run[%0d]: got %b want %b", i, o, e); end
    end
  endtask
  initial begin
    test_reset();
    test_heat_hold();
    test_pulse();
    test_lockout_req();
    test_conflict();
    test_abort_pre();
    test_reset_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
